// File: rtl/fetch_instruction_pkg.sv
// Shared constants and FSM encoding for the stack CPU instruction fetch unit.
package fetch_instruction_pkg;

    localparam int unsigned ADDRESS_BITS = 8;
    localparam int unsigned DATA_BITS    = 16;

    localparam logic RAM_READ  = 1'b0;
    localparam logic RAM_WRITE = 1'b1;

    typedef enum logic [0:0] {
        FETCH_ADDR  = 1'b0,
        FETCH_LATCH = 1'b1
    } fetchStateT;

endpackage

// File: rtl/fetch_instruction_if.sv
// Fetch unit bus: PC selection in, fetched byte out, and the IceRam read port.
interface fetch_instruction_if
    import fetch_instruction_pkg::*;
#(
    parameter int unsigned addrBits = ADDRESS_BITS,
    parameter int unsigned dataBits = DATA_BITS
);

    logic                useInternalProgramCounter;
    logic [8:0]          programCounter;
    logic [addrBits-1:0] programAddress;
    logic                programRw;
    logic [dataBits-1:0] programDataOut;
    logic [7:0]          instruction;
    logic [8:0]          nextProgramCounter;
    logic                fetchWillFinish;

    modport master (
        input  useInternalProgramCounter,
        input  programCounter,
        input  programDataOut,
        output programAddress,
        output programRw,
        output instruction,
        output nextProgramCounter,
        output fetchWillFinish
    );

    modport slave (
        output useInternalProgramCounter,
        output programCounter,
        output programDataOut,
        input  programAddress,
        input  programRw,
        input  instruction,
        input  nextProgramCounter,
        input  fetchWillFinish
    );

endinterface

// File: rtl/fetch_instruction.sv
// Two-cycle instruction fetch: present a word address, then latch the selected byte
// from the 1-cycle-latency program RAM.
module fetch_instruction
    import fetch_instruction_pkg::*;
#(
    parameter int unsigned addrBits = ADDRESS_BITS,
    parameter int unsigned dataBits = DATA_BITS
) (
    input logic                 clk,
    input logic                 reset,
    fetch_instruction_if.master bus
);

    fetchStateT          state;
    logic [8:0]          pcReg;
    logic [8:0]          internalPc;
    logic [7:0]          instructionReg;
    logic [8:0]          nextPcReg;
    logic                fetchWillFinishReg;
    logic [8:0]          selPc;
    logic [addrBits-1:0] addrComb;
    logic [dataBits-1:0] ramWord;

    assign ramWord = bus.programDataOut;
    assign selPc   = bus.useInternalProgramCounter ? internalPc : bus.programCounter;

    // Address follows the selected PC while in ADDR, then holds pcReg so the RAM
    // output stays tied to the fetch in flight.
    always_comb begin
        addrComb      = '0;
        addrComb[7:0] = (state == FETCH_ADDR) ? selPc[8:1] : pcReg[8:1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= FETCH_ADDR;
            pcReg              <= '0;
            internalPc         <= '0;
            instructionReg     <= '0;
            nextPcReg          <= '0;
            fetchWillFinishReg <= 1'b0;
        end else begin
            case (state)
                FETCH_ADDR: begin
                    pcReg              <= selPc;
                    fetchWillFinishReg <= 1'b1;
                    state              <= FETCH_LATCH;
                end
                FETCH_LATCH: begin
                    // Big-endian packing: even byte lives in the high half of the word.
                    instructionReg     <= pcReg[0] ? ramWord[7:0] : ramWord[15:8];
                    nextPcReg          <= pcReg + 9'd1;
                    internalPc         <= pcReg + 9'd1;
                    fetchWillFinishReg <= 1'b0;
                    state              <= FETCH_ADDR;
                end
                default: begin
                    state              <= FETCH_ADDR;
                    fetchWillFinishReg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.programAddress     = addrComb;
    assign bus.programRw          = RAM_READ;
    assign bus.instruction        = instructionReg;
    assign bus.nextProgramCounter = nextPcReg;
    assign bus.fetchWillFinish    = fetchWillFinishReg;

endmodule

// File: tb/tb_fetch_instruction.sv
// Scoreboard bench for fetch_instruction with an IceRam model holding byte n = n mod 256.
`timescale 1ns/100ps
module tb_fetch_instruction;
    import fetch_instruction_pkg::*;

    typedef struct {
        logic [7:0] instr;
        logic [8:0] npc;
    } expT;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #1 clk = ~clk;

    fetch_instruction_if #(.addrBits(ADDRESS_BITS), .dataBits(DATA_BITS)) bus();

    fetch_instruction dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    logic [15:0] ram [256];
    initial begin
        for (int i = 0; i < 256; i++) ram[i] = {8'(2 * i), 8'(2 * i + 1)};
    end
    always @(posedge clk) begin
        if (bus.programRw == RAM_READ) bus.programDataOut <= ram[bus.programAddress[7:0]];
    end

    expT        sbq[$];
    int         vectors = 0;
    int         miscompares = 0;
    logic [8:0] modelPc = '0;
    logic [7:0] heldInstr = '0;
    logic [8:0] heldNpc = '0;
    bit         stimDone = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Called at a negedge while the DUT is in its ADDR cycle.
    task automatic doFetch(input bit useInt, input logic [8:0] pc, input bit disturb);
        logic [8:0] sel;
        check("fwfAddr", 16'(bus.fetchWillFinish), 16'd0);
        bus.useInternalProgramCounter = useInt;
        bus.programCounter            = pc;
        sel = useInt ? modelPc : pc;
        sbq.push_back('{instr: sel[7:0], npc: sel + 9'd1});
        modelPc = sel + 9'd1;
        #0.2;
        check("addrAddr", 16'(bus.programAddress), 16'(sel[8:1]));
        @(negedge clk);
        check("fwfLatch", 16'(bus.fetchWillFinish), 16'd1);
        check("heldInstr", 16'(bus.instruction), 16'(heldInstr));
        check("heldNpc", 16'(bus.nextProgramCounter), 16'(heldNpc));
        if (disturb) begin
            bus.useInternalProgramCounter = 1'($urandom_range(0, 1));
            bus.programCounter            = 9'($urandom_range(0, 511));
        end
        #0.2;
        check("addrLatch", 16'(bus.programAddress), 16'(sel[8:1]));
        heldInstr = sel[7:0];
        heldNpc   = sel + 9'd1;
        @(negedge clk);
    endtask

    // Start a fetch, then hit reset during its LATCH cycle.
    task automatic resetMidFetch();
        bus.useInternalProgramCounter = 1'($urandom_range(0, 1));
        bus.programCounter            = 9'($urandom_range(0, 511));
        @(negedge clk);
        #0.5;
        reset = 1'b1;
        sbq.delete();
        modelPc   = '0;
        heldInstr = '0;
        heldNpc   = '0;
        #0.2;
        check("rstInstr", 16'(bus.instruction), 16'd0);
        check("rstNpc", 16'(bus.nextProgramCounter), 16'd0);
        check("rstFwf", 16'(bus.fetchWillFinish), 16'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: every completed fetch is compared against the head of the scoreboard.
    initial begin
        expT e;
        forever begin
            @(negedge clk);
            if (!reset && bus.fetchWillFinish) begin
                @(posedge clk);
                #0.5;
                if (!reset) begin
                    if (sbq.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpectedFetch: got %h/%h expected none",
                                 bus.instruction, bus.nextProgramCounter);
                    end else begin
                        e = sbq.pop_front();
                        check("instruction", 16'(bus.instruction), 16'(e.instr));
                        check("nextProgramCounter", 16'(bus.nextProgramCounter), 16'(e.npc));
                    end
                end
            end
        end
    end

    initial begin
        bus.useInternalProgramCounter = 1'b0;
        bus.programCounter            = '0;
        #0.5;
        check("initInstr", 16'(bus.instruction), 16'd0);
        check("initNpc", 16'(bus.nextProgramCounter), 16'd0);
        check("initFwf", 16'(bus.fetchWillFinish), 16'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        doFetch(1'b0, 9'd0, 1'b0);
        doFetch(1'b1, 9'd300, 1'b0);
        doFetch(1'b1, 9'd77, 1'b0);
        doFetch(1'b0, 9'd14, 1'b0);
        doFetch(1'b0, 9'd511, 1'b0);
        doFetch(1'b1, 9'd5, 1'b0);
        resetMidFetch();
        doFetch(1'b1, 9'd200, 1'b0);
        doFetch(1'b0, 9'd100, 1'b1);
        doFetch(1'b1, 9'd0, 1'b1);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 49) == 0) resetMidFetch();
            else doFetch(1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)),
                         1'($urandom_range(0, 1)));
        end

        for (int w = 0; w < 10 && sbq.size() != 0; w++) @(negedge clk);
        if (sbq.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        stimDone = 1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
